// File: rtl/priority_scan_encoder_pkg.sv
// Shared types and constants for the priority scan encoder slice.
// Holds the FSM state type, the operating-mode constants and the index-width helper.
package encoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam int MODE_SCAN   = 0;
  localparam int MODE_ONEHOT = 1;

  function automatic int idx_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/priority_scan_encoder_if.sv
// Request-vector and index-beat handshakes of the priority scan encoder.
// The encoder connects through the slave modport and its driver through the master modport.
interface priority_scan_encoder_if #(
  parameter int WIDTH = 16
);
  import encoder_pkg::*;

  localparam int IDX_W = idx_width(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             out_err;

  modport slave (
    input  in_valid,
    input  in_vec,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_idx,
    output out_last,
    output out_err
  );

  modport master (
    output in_valid,
    output in_vec,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_idx,
    input  out_last,
    input  out_err
  );

endinterface

// File: rtl/priority_scan_encoder_ffs.sv
// Combinational find-first-set over a WIDTH-bit vector.
// Reports the priority bit index plus whether any bit, and whether more than one bit, is set.
module ffs_index
  import encoder_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int LSB_FIRST = 1,
  localparam int IDX_W    = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any,
  output logic             o_multi
);

  logic [IDX_W-1:0] w_lowIdx;
  logic [IDX_W-1:0] w_highIdx;

  // The last matching bit of each sweep wins, giving the lowest and highest set bit.
  always_comb begin
    w_lowIdx  = '0;
    w_highIdx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_vec[i]) w_lowIdx = IDX_W'(i);
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (i_vec[i]) w_highIdx = IDX_W'(i);
    end
  end

  assign o_idx   = (LSB_FIRST != 0) ? w_lowIdx : w_highIdx;
  assign o_any   = |i_vec;
  assign o_multi = |(i_vec & (i_vec - WIDTH'(1)));

endmodule

// File: rtl/priority_scan_encoder.sv
// Registered priority scan encoder: captures a request vector and emits its set-bit indices
// as valid/ready beats, either one per set bit (scan) or a single strict one-hot beat.
module priority_scan_encoder
  import encoder_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MODE      = MODE_SCAN,
  parameter int LSB_FIRST = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  output logic                    busy,
  priority_scan_encoder_if.slave  bus
);

  localparam int   IDX_W  = idx_width(WIDTH);
  localparam logic ONEHOT = (MODE == MODE_ONEHOT);

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_pend;
  logic [WIDTH-1:0] w_clearMask;
  logic [IDX_W-1:0] w_ffsIdx;
  logic             w_any;
  logic             w_multi;
  logic             w_inReady;
  logic             w_accept;
  logic             w_beatDone;
  logic             w_outValid;
  logic [IDX_W-1:0] w_outIdx;
  logic             w_outLast;
  logic             w_outErr;
  logic             w_busy;

  ffs_index #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_ffs (
    .i_vec   (r_pend),
    .o_idx   (w_ffsIdx),
    .o_any   (w_any),
    .o_multi (w_multi)
  );

  assign w_inReady   = (r_state == IDLE) & enable & ~reset;
  assign w_accept    = bus.in_valid & w_inReady;
  assign w_beatDone  = w_outValid & bus.out_ready;
  assign w_clearMask = WIDTH'(1) << w_ffsIdx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (w_accept) w_nextState = SCAN;
      SCAN: if (w_beatDone && (ONEHOT || w_outLast)) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Outputs come only from r_state and r_pend, so they stay stable under backpressure.
  always_comb begin
    w_busy     = (r_state == SCAN);
    w_outValid = w_busy;
    w_outIdx   = (w_busy && w_any) ? w_ffsIdx : '0;
    w_outLast  = w_busy & (ONEHOT | ~w_multi);
    w_outErr   = w_busy & (~w_any | (ONEHOT & w_multi));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= '0;
    end else if (w_accept) begin
      r_pend <= bus.in_vec;
    end else if (w_beatDone) begin
      r_pend <= ONEHOT ? '0 : (r_pend & ~w_clearMask);
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = w_outValid;
  assign bus.out_idx   = w_outIdx;
  assign bus.out_last  = w_outLast;
  assign bus.out_err   = w_outErr;
  assign busy          = w_busy;

endmodule
